// File: rtl/button_conditioner_pkg.sv
// Shared debounce definitions: the per-channel state encoding and the default
// debounce interval, visible to the camera/top-level benches as well.
package button_conditioner_pkg;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;  // 10 ms @ 100 MHz

    typedef enum logic [1:0] {
        DB_RELEASED     = 2'd0,
        DB_PRESS_WAIT   = 2'd1,
        DB_PRESSED      = 2'd2,
        DB_RELEASE_WAIT = 2'd3
    } db_state_t;

endpackage

// File: rtl/debounce_channel.sv
// One pushbutton channel: 2-FF synchroniser, debounce FSM with qualification
// counter, registered level and 1-cycle press/release pulses.
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic fast_clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1, s2;
    db_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             level_next;

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // >= rather than == so DEBOUNCE_CYCLES=1 (CNT_LAST=0) accepts on the first
    // wait cycle instead of wrapping; identical for all larger values.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            DB_RELEASED: begin
                if (s2) begin
                    state_next = DB_PRESS_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            DB_PRESS_WAIT: begin
                if (!s2) begin
                    state_next = DB_RELEASED;
                    cnt_next   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_next = DB_PRESSED;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            DB_PRESSED: begin
                if (!s2) begin
                    state_next = DB_RELEASE_WAIT;
                    cnt_next   = CNT_ONE;
                end
            end
            DB_RELEASE_WAIT: begin
                if (s2) begin
                    state_next = DB_PRESSED;
                    cnt_next   = '0;
                end else if (cnt >= CNT_LAST) begin
                    state_next = DB_RELEASED;
                    cnt_next   = '0;
                end else begin
                    cnt_next   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_next = DB_RELEASED;
                cnt_next   = '0;
            end
        endcase
    end

    assign level_next = (state == DB_PRESSED) || (state == DB_RELEASE_WAIT);

    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state         <= DB_RELEASED;
            cnt           <= '0;
            level         <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state         <= state_next;
            cnt           <= cnt_next;
            level         <= level_next;
            press_pulse   <= level_next & ~level;
            release_pulse <= ~level_next & level;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Left/right pushbutton conditioner: two independent debounce channels feeding
// the camera controller FSM.
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic fast_clk,
    input  logic rst,
    input  logic btn_left_raw,
    input  logic btn_right_raw,
    output logic leftB,
    output logic rightB,
    output logic left_press,
    output logic left_release,
    output logic right_press,
    output logic right_release
);

    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0] raw, level, press_pulse, release_pulse;

    // Channel 0 = left, channel 1 = right.
    assign raw = {btn_right_raw, btn_left_raw};

    generate
        for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
            debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_ch (
                .fast_clk      (fast_clk),
                .rst           (rst),
                .raw           (raw[c]),
                .level         (level[c]),
                .press_pulse   (press_pulse[c]),
                .release_pulse (release_pulse[c])
            );
        end
    endgenerate

    assign leftB         = level[0];
    assign rightB        = level[1];
    assign left_press    = press_pulse[0];
    assign right_press   = press_pulse[1];
    assign left_release  = release_pulse[0];
    assign right_release = release_pulse[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus randomized holds,
// checked against a run-length model of the debounce rule.
module tb_button_conditioner;

    localparam int D = 8;

    logic fast_clk = 1'b0;
    logic rst = 1'b0;
    logic btn_left_raw = 1'b0;
    logic btn_right_raw = 1'b0;
    logic leftB, rightB, left_press, left_release, right_press, right_release;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model: value delayed two edges, accepted once it has disagreed with the
    // current accepted value for D consecutive samples; output one edge later.
    logic m_s1[2], m_s2[2], m_acc[2], m_lvl[2], m_prs[2], m_rls[2];
    int   m_run[2];
    int   press_cnt[2], release_cnt[2];

    button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
        .fast_clk      (fast_clk),
        .rst           (rst),
        .btn_left_raw  (btn_left_raw),
        .btn_right_raw (btn_right_raw),
        .leftB         (leftB),
        .rightB        (rightB),
        .left_press    (left_press),
        .left_release  (left_release),
        .right_press   (right_press),
        .right_release (right_release)
    );

    always #5 fast_clk = ~fast_clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %b, want %b (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_acc[c] = 1'b0;
            m_lvl[c] = 1'b0; m_prs[c] = 1'b0; m_rls[c] = 1'b0;
            m_run[c] = 0;
        end
        cyc = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_leftB"}, leftB, 1'b0);
        chk({tag, "_rightB"}, rightB, 1'b0);
        chk({tag, "_lpress"}, left_press, 1'b0);
        chk({tag, "_lrelease"}, left_release, 1'b0);
        chk({tag, "_rpress"}, right_press, 1'b0);
        chk({tag, "_rrelease"}, right_release, 1'b0);
    endtask

    // One clock: inputs already set; advance model, sample DUT 1 time unit later.
    task automatic step();
        logic raw[2];
        logic fsm_in;
        raw[0] = btn_left_raw;
        raw[1] = btn_right_raw;
        @(posedge fast_clk);
        for (int c = 0; c < 2; c++) begin
            fsm_in   = m_s2[c];
            m_s2[c]  = m_s1[c];
            m_s1[c]  = raw[c];
            m_prs[c] = m_acc[c] & ~m_lvl[c];
            m_rls[c] = ~m_acc[c] & m_lvl[c];
            m_lvl[c] = m_acc[c];
            if (fsm_in != m_acc[c]) begin
                m_run[c]++;
                if (m_run[c] == D) begin
                    m_acc[c] = fsm_in;
                    m_run[c] = 0;
                end
            end else begin
                m_run[c] = 0;
            end
        end
        cyc++;
        #1;
        chk("leftB", leftB, m_lvl[0]);
        chk("rightB", rightB, m_lvl[1]);
        chk("left_press", left_press, m_prs[0]);
        chk("left_release", left_release, m_rls[0]);
        chk("right_press", right_press, m_prs[1]);
        chk("right_release", right_release, m_rls[1]);
        press_cnt[0]   += int'(left_press);
        press_cnt[1]   += int'(right_press);
        release_cnt[0] += int'(left_release);
        release_cnt[1] += int'(right_release);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Called at posedge+1 with rst already high: hold two edges, then release.
    task automatic release_reset();
        @(posedge fast_clk);
        @(posedge fast_clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int l_rise, r_rise, p0, r0, t0;
        int hold[2];

        for (int c = 0; c < 2; c++) begin
            press_cnt[c] = 0;
            release_cnt[c] = 0;
        end
        model_reset();

        // Reset with both raw inputs held high.
        btn_left_raw = 1'b1;
        btn_right_raw = 1'b1;
        #2 rst = 1'b1;
        #1 chk_zero("reset");
        release_reset();
        l_rise = -1;
        p0 = press_cnt[0];
        for (int i = 0; i < 20; i++) begin
            step();
            if (leftB && l_rise < 0) l_rise = cyc;
        end
        chk_int("press_latency", l_rise, 2 + D + 1);
        chk_int("reset_hold_presses", press_cnt[0] - p0, 1);

        // Bounce every 3 cycles, then hold high.
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        steps(20);
        p0 = press_cnt[0];
        for (int i = 0; i < 40; i++) begin
            btn_left_raw = ((i / 3) % 2) == 0;
            step();
        end
        chk_int("bounce_no_press", press_cnt[0] - p0, 0);
        btn_left_raw = 1'b1;
        steps(20);
        chk_int("bounce_one_press", press_cnt[0] - p0, 1);

        // Release glitch of 5 cycles, then a real release.
        r0 = release_cnt[0];
        btn_left_raw = 1'b0;
        steps(5);
        btn_left_raw = 1'b1;
        steps(10);
        chk_int("glitch_no_release", release_cnt[0] - r0, 0);
        chk("glitch_level_held", leftB, 1'b1);
        btn_left_raw = 1'b0;
        steps(20);
        chk_int("one_release", release_cnt[0] - r0, 1);
        chk("released_level", leftB, 1'b0);

        // Both channels pressed on the same cycle.
        btn_left_raw = 1'b1;
        btn_right_raw = 1'b1;
        t0 = cyc;
        l_rise = -1;
        r_rise = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (leftB && l_rise < 0) l_rise = cyc - t0;
            if (rightB && r_rise < 0) r_rise = cyc - t0;
        end
        chk_int("indep_left_rise", l_rise, 2 + D + 1);
        chk_int("indep_right_rise", r_rise, 2 + D + 1);
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        steps(20);

        // Reset during PRESS_WAIT.
        btn_left_raw = 1'b1;
        steps(6);
        rst = 1'b1;
        #1 chk_zero("rst_pw");
        btn_left_raw = 1'b0;
        release_reset();
        steps(20);

        // Reset while PRESSED: level drops, no release pulse.
        btn_left_raw = 1'b1;
        btn_right_raw = 1'b1;
        steps(15);
        chk("pressed_before_rst", leftB, 1'b1);
        rst = 1'b1;
        #1 chk_zero("rst_pressed");
        btn_left_raw = 1'b0;
        btn_right_raw = 1'b0;
        release_reset();
        steps(20);

        // Edge value: 7 samples rejected, 8 accepted.
        p0 = press_cnt[0];
        r0 = release_cnt[0];
        btn_left_raw = 1'b1;
        steps(7);
        btn_left_raw = 1'b0;
        steps(20);
        chk_int("edge7_no_press", press_cnt[0] - p0, 0);
        btn_left_raw = 1'b1;
        steps(8);
        btn_left_raw = 1'b0;
        steps(25);
        chk_int("edge8_press", press_cnt[0] - p0, 1);
        chk_int("edge8_release", release_cnt[0] - r0, 1);

        // Randomized independent hold lengths straddling the debounce interval.
        hold[0] = 0;
        hold[1] = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold[0] == 0) begin
                btn_left_raw = ~btn_left_raw;
                hold[0] = int'($urandom_range(1, 14));
            end
            if (hold[1] == 0) begin
                btn_right_raw = ~btn_right_raw;
                hold[1] = int'($urandom_range(1, 14));
            end
            hold[0]--;
            hold[1]--;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
